d_latch_writer: RTL and testbench

Clocked write sequencer that drives the D/En inputs of a WIDTH-bit bank of transparent D latches, then reads back Q/Qbar to confirm the store. It enforces programmable setup, enable-pulse and hold intervals around each write. A completion/error handshake is presented to the controlling logic. It sits between synchronous control logic and latch-based storage. It is the writing end of the latch interface that the D_latch cell receives.

---
 rtl/d_latch_writer.sv | 107 ++++++++++
 tb/tb_d_latch_writer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/d_latch_writer.sv
// Write sequencer for a bank of transparent D latches: drives D/En with programmable
// setup, enable-pulse and hold intervals, then confirms the store through Q/Qbar.
module d_latch_writer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Data_in,
    output logic [WIDTH-1:0] D,
    output logic             En,
    input  logic [WIDTH-1:0] Q,
    input  logic [WIDTH-1:0] Qbar,
    output logic             Busy,
    output logic             Done,
    output logic             Error
);

    localparam int unsigned MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int unsigned MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] word;
    logic             mismatch_c;

    // Readback is only meaningful on the last hold edge, where the latches are closed.
    assign mismatch_c = (Q != word) || (Qbar != ~word);

    // Sequencer: each interval counts down from its length minus one to zero.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
            word  <= '0;
            D     <= '0;
            En    <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            Error <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        D     <= Data_in;
                        word  <= Data_in;
                        Busy  <= 1'b1;
                        Error <= 1'b0;
                        cnt   <= SETUP_LOAD;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        En    <= 1'b1;
                        cnt   <= PULSE_LOAD;
                        state <= PULSE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        En    <= 1'b0;
                        cnt   <= HOLD_LOAD;
                        state <= HOLD;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        Error <= mismatch_c;
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    En    <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_d_latch_writer.sv
// Bench for d_latch_writer: default-timing and (2,3,2)-timing instances share stimulus,
// each drives its own latch model; an interval-based model is compared every cycle.
module tb_d_latch_writer;

    localparam int unsigned SC[2] = '{1, 2};
    localparam int unsigned PC[2] = '{2, 3};
    localparam int unsigned HC[2] = '{1, 2};

    logic       Clk;
    logic       Reset;
    logic       Start;
    logic [7:0] Data_in;
    logic [7:0] stuck0;
    logic [7:0] stuck1;

    logic [7:0] d_o[2];
    logic [7:0] q_i[2];
    logic [7:0] qb_i[2];
    logic       en_o[2];
    logic       busy_o[2];
    logic       done_o[2];
    logic       err_o[2];
    logic [7:0] lat0;
    logic [7:0] lat1;

    int checks;
    int errors;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    d_latch_writer #(.WIDTH(8), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)) u_dut0 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Data_in(Data_in),
        .D(d_o[0]), .En(en_o[0]), .Q(q_i[0]), .Qbar(qb_i[0]),
        .Busy(busy_o[0]), .Done(done_o[0]), .Error(err_o[0])
    );

    d_latch_writer #(.WIDTH(8), .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)) u_dut1 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Data_in(Data_in),
        .D(d_o[1]), .En(en_o[1]), .Q(q_i[1]), .Qbar(qb_i[1]),
        .Busy(busy_o[1]), .Done(done_o[1]), .Error(err_o[1])
    );

    // Transparent latch banks with optional stuck-at faults on the stored bits.
    always @* if (en_o[0]) lat0 = d_o[0];
    always @* if (en_o[1]) lat1 = d_o[1];
    assign q_i[0]  = (lat0 & ~stuck0) | stuck1;
    assign q_i[1]  = (lat1 & ~stuck0) | stuck1;
    assign qb_i[0] = ~q_i[0];
    assign qb_i[1] = ~q_i[1];

    // Model: a write is an elapsed-cycle count since acceptance.
    bit          m_act[2];
    int unsigned m_t[2];
    logic [7:0]  m_w[2];
    bit          m_done[2];
    bit          m_err[2];

    always @(posedge Clk or posedge Reset) begin
        for (int i = 0; i < 2; i++) begin
            if (Reset) begin
                m_act[i]  = 1'b0;
                m_t[i]    = 0;
                m_w[i]    = 8'h00;
                m_done[i] = 1'b0;
                m_err[i]  = 1'b0;
            end else begin
                m_done[i] = 1'b0;
                if (m_act[i]) begin
                    m_t[i] = m_t[i] + 1;
                    if (m_t[i] == SC[i] + PC[i] + HC[i]) begin
                        m_act[i]  = 1'b0;
                        m_done[i] = 1'b1;
                        m_err[i]  = (q_i[i] != m_w[i]) || (qb_i[i] != ~m_w[i]);
                    end
                end else if (Start) begin
                    m_act[i] = 1'b1;
                    m_t[i]   = 0;
                    m_w[i]   = Data_in;
                    m_err[i] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string nm, input int i, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] at %0t: got %h, expected %h", nm, i, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge Clk) begin
        for (int i = 0; i < 2; i++) begin
            check("D", i, d_o[i], m_w[i]);
            check("En", i, 8'(en_o[i]), 8'(m_act[i] && m_t[i] >= SC[i] && m_t[i] < SC[i] + PC[i]));
            check("Busy", i, 8'(busy_o[i]), 8'(m_act[i]));
            check("Done", i, 8'(done_o[i]), 8'(m_done[i]));
            check("Error", i, 8'(err_o[i]), 8'(m_err[i]));
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] v);
        @(negedge Clk);
        Start   = 1'b1;
        Data_in = v;
        tick();
    endtask

    task automatic release_start();
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic wait_idle(output int n0);
        bool_loop: begin
            n0 = 0;
            for (int c = 0; c < 40; c++) begin
                if (!busy_o[0] && !busy_o[1]) disable bool_loop;
                tick();
                if (done_o[0]) n0++;
            end
            checks++;
            errors++;
            $display("FAIL idle_timeout: Busy still high after 40 cycles, required low");
        end
    endtask

    int         n;
    int         first_done;
    int         second_done;
    logic [8:0] en_tab;
    logic [8:0] done_tab;

    initial begin
        checks  = 0;
        errors  = 0;
        Reset   = 1'b1;
        Start   = 1'b0;
        Data_in = 8'h00;
        stuck0  = 8'h00;
        stuck1  = 8'h00;
        #12 Reset = 1'b0;
        check("rst_D", 0, d_o[0], 8'h00);
        check("rst_En", 0, 8'(en_o[0]), 8'h00);
        check("rst_Busy", 0, 8'(busy_o[0]), 8'h00);
        check("rst_Done", 0, 8'(done_o[0]), 8'h00);
        check("rst_Error", 0, 8'(err_o[0]), 8'h00);

        // Basic A5 write with default timing.
        accept(8'hA5);
        check("t1_D_e0", 0, d_o[0], 8'hA5);
        check("t1_Busy_e0", 0, 8'(busy_o[0]), 8'h01);
        check("t1_En_e0", 0, 8'(en_o[0]), 8'h00);
        release_start();
        tick(); check("t1_En_e1", 0, 8'(en_o[0]), 8'h01);
        tick(); check("t1_En_e2", 0, 8'(en_o[0]), 8'h01);
        tick(); check("t1_En_e3", 0, 8'(en_o[0]), 8'h00);
        tick();
        check("t1_Done_e4", 0, 8'(done_o[0]), 8'h01);
        check("t1_Busy_e4", 0, 8'(busy_o[0]), 8'h00);
        check("t1_Error_e4", 0, 8'(err_o[0]), 8'h00);
        check("t1_Q", 0, q_i[0], 8'hA5);
        check("t1_Qbar", 0, qb_i[0], 8'h5A);
        tick(); check("t1_Done_e5", 0, 8'(done_o[0]), 8'h00);
        wait_idle(n);

        // Bit 3 stuck at 0: invisible for A5, caught for 0F, cleared by the next accept.
        stuck0 = 8'h08;
        accept(8'hA5); release_start(); wait_idle(n);
        check("t2_A5_err", 0, 8'(err_o[0]), 8'h00);
        accept(8'h0F); release_start(); wait_idle(n);
        check("t2_0F_err", 0, 8'(err_o[0]), 8'h01);
        check("t2_0F_dones", 0, 8'(n), 8'h01);
        stuck0 = 8'h00;
        accept(8'h00);
        check("t2_err_clr", 0, 8'(err_o[0]), 8'h00);
        release_start(); wait_idle(n);
        check("t2_err_done", 0, 8'(err_o[0]), 8'h00);

        // Start re-pulsed while busy is ignored.
        accept(8'h3C);
        @(negedge Clk); Data_in = 8'hFF;
        tick(); check("t3_D_e1", 0, d_o[0], 8'h3C);
        tick(); check("t3_D_e2", 0, d_o[0], 8'h3C);
        release_start(); wait_idle(n);
        check("t3_dones", 0, 8'(n), 8'h01);
        check("t3_D_end", 0, d_o[0], 8'h3C);

        // Back-to-back: Start held, second word accepted on the edge where Done is visible.
        accept(8'h11);
        Data_in     = 8'h22;
        n           = 0;
        first_done  = -1;
        second_done = -1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge Clk);
            if (c == 6) Start = 1'b0;
            tick();
            if (c == 5) check("t4_D_e5", 0, d_o[0], 8'h22);
            if (done_o[0]) begin
                n++;
                if (first_done < 0) first_done = c; else second_done = c;
            end
        end
        check("t4_dones", 0, 8'(n), 8'h02);
        check("t4_first", 0, 8'(first_done), 8'h04);
        check("t4_gap", 0, 8'(second_done - first_done), 8'h05);
        wait_idle(n);

        // Asynchronous reset during the enable pulse.
        accept(8'h77); release_start();
        tick();
        check("t5_En_e1", 0, 8'(en_o[0]), 8'h01);
        #2 Reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("t5_En_rst", i, 8'(en_o[i]), 8'h00);
            check("t5_D_rst", i, d_o[i], 8'h00);
            check("t5_Busy_rst", i, 8'(busy_o[i]), 8'h00);
        end
        @(negedge Clk); @(negedge Clk); Reset = 1'b0;
        n = 0;
        repeat (6) begin
            tick();
            if (done_o[0]) n++;
        end
        check("t5_no_done", 0, 8'(n), 8'h00);
        accept(8'h5A); release_start(); wait_idle(n);
        check("t5_dones", 0, 8'(n), 8'h01);
        check("t5_err", 0, 8'(err_o[0]), 8'h00);
        check("t5_Q", 0, q_i[0], 8'h5A);

        // Long-timing instance: En after edges 2-4, Done after edge 7.
        en_tab   = 9'b0_0001_1100;
        done_tab = 9'b0_1000_0000;
        accept(8'hC3);
        check("t6_D_e0", 1, d_o[1], 8'hC3);
        check("t6_En_e0", 1, 8'(en_o[1]), 8'h00);
        release_start();
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c <= 7) check("t6_D", 1, d_o[1], 8'hC3);
            check("t6_En", 1, 8'(en_o[1]), 8'(en_tab[c]));
            check("t6_Done", 1, 8'(done_o[1]), 8'(done_tab[c]));
        end
        check("t6_err", 1, 8'(err_o[1]), 8'h00);
        wait_idle(n);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
